// File: rtl/bpu_ram_1r1w_clr.sv
// One-read/one-write predictor table RAM with lane write masks and a self-clearing init walk.
// Optional macro BPU_RAM_WR_BYPASS_EN forwards same-cycle write data to a colliding read.
module bpu_ram_1r1w_clr #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 512,
  parameter int                    MASK_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic                  we,
  input  logic [MASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  localparam int                    L_LANE_W = DATA_WIDTH / MASK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] L_LAST   = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_ready;
  logic                  w_waddr_ok;
  logic                  w_raddr_ok;
  logic                  w_ext_we;

  assign w_ready    = (r_state == S_READY);
  assign ready      = w_ready;
  assign w_waddr_ok = (32'(waddr) < DEPTH);
  assign w_raddr_ok = (32'(raddr) < DEPTH);
  assign w_ext_we   = w_ready & we & w_waddr_ok;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        if (r_cnt == L_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_READY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (clr_req) w_state_nxt = S_INIT;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // NOTE: the array has no reset so it maps onto RAM macros; the init walk clears it instead.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_mem[r_cnt] <= INIT_VALUE;
    end else if (w_ext_we) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wmask[i]) r_mem[waddr][i*L_LANE_W +: L_LANE_W] <= wdata[i*L_LANE_W +: L_LANE_W];
      end
    end
  end

  always_comb begin
    w_rd_word = INIT_VALUE;
    if (w_raddr_ok) begin
      w_rd_word = r_mem[raddr];
`ifdef BPU_RAM_WR_BYPASS_EN
      if (w_ext_we && (waddr == raddr)) begin
        for (int i = 0; i < MASK_WIDTH; i++) begin
          if (wmask[i]) w_rd_word[i*L_LANE_W +: L_LANE_W] = wdata[i*L_LANE_W +: L_LANE_W];
        end
      end
`endif
    end
  end

  // Reads are accepted in the same cycle as a flush request; only the walk blocks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= w_ready & re;
      if (w_ready && re) rdata <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_bpu_ram_1r1w_clr.sv
// Self-checking bench for bpu_ram_1r1w_clr: a 512-entry instance checked against a behavioural
// model plus a 100-entry instance with a non-zero init value for the non-power-of-two cases.
module tb_bpu_ram_1r1w_clr;

  localparam logic [31:0] INIT_A = 32'h0;
  localparam logic [31:0] INIT_B = 32'hA5A5_5A5A;
`ifdef BPU_RAM_WR_BYPASS_EN
  localparam logic [31:0] EXP_SAME = 32'h1234_5678;
`else
  localparam logic [31:0] EXP_SAME = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_clr = 1'b0, a_we = 1'b0, a_re = 1'b0;
  logic [3:0]  a_wmask = '0;
  logic [8:0]  a_waddr = '0, a_raddr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_ready, a_rvalid;
  logic [31:0] a_rdata;

  logic        b_clr = 1'b0, b_we = 1'b0, b_re = 1'b0;
  logic [3:0]  b_wmask = '0;
  logic [6:0]  b_waddr = '0, b_raddr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_ready, b_rvalid;
  logic [31:0] b_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bpu_ram_1r1w_clr #(.DATA_WIDTH(32), .DEPTH(512), .MASK_WIDTH(4), .INIT_VALUE(INIT_A)) u_dut_a (
    .clk(clk), .rst(rst), .clr_req(a_clr), .ready(a_ready),
    .we(a_we), .wmask(a_wmask), .waddr(a_waddr), .wdata(a_wdata),
    .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid)
  );

  bpu_ram_1r1w_clr #(.DATA_WIDTH(32), .DEPTH(100), .MASK_WIDTH(4), .INIT_VALUE(INIT_B)) u_dut_b (
    .clk(clk), .rst(rst), .clr_req(b_clr), .ready(b_ready),
    .we(b_we), .wmask(b_wmask), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid)
  );

  // Reference model of instance A: contents, remaining busy cycles and the output registers.
  logic [31:0] m_mem [512];
  int          m_busy;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = INIT_A;
    m_busy   = 512;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic model_step(input logic we_i, input logic [3:0] mask_i, input logic [8:0] wa_i,
                            input logic [31:0] wd_i, input logic re_i, input logic [8:0] ra_i,
                            input logic clr_i);
    logic [31:0] rd;
    logic [31:0] lm;
    if (m_busy > 0) begin
      m_busy--;
      m_rvalid = 1'b0;
    end else begin
      lm = lane_bits(mask_i);
      rd = m_mem[ra_i];
`ifdef BPU_RAM_WR_BYPASS_EN
      if (we_i && wa_i == ra_i) rd = (wd_i & lm) | (rd & ~lm);
`endif
      if (we_i) m_mem[wa_i] = (wd_i & lm) | (m_mem[wa_i] & ~lm);
      m_rvalid = re_i;
      if (re_i) m_rdata = rd;
      if (clr_i) begin
        foreach (m_mem[i]) m_mem[i] = INIT_A;
        m_busy = 512;
      end
    end
  endtask

  // One clock for both instances; instance A is driven from the arguments and checked every cycle.
  task automatic cyc_a(input logic we_i, input logic [3:0] mask_i, input logic [8:0] wa_i,
                       input logic [31:0] wd_i, input logic re_i, input logic [8:0] ra_i,
                       input logic clr_i);
    a_we = we_i; a_wmask = mask_i; a_waddr = wa_i; a_wdata = wd_i;
    a_re = re_i; a_raddr = ra_i; a_clr = clr_i;
    @(posedge clk);
    #1;
    model_step(we_i, mask_i, wa_i, wd_i, re_i, ra_i, clr_i);
    check("a_outputs", 64'({a_ready, a_rvalid, a_rdata}),
          64'({(m_busy == 0), m_rvalid, m_rdata}));
    a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
  endtask

  task automatic idle_a();
    cyc_a(1'b0, 4'h0, 9'd0, 32'h0, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic read_a(input logic [8:0] ra_i);
    cyc_a(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, ra_i, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [8:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [8:0]  raddr;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd0,   1'b1, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd255, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd511, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 4'h5, 9'd7,   32'hDEAD_BEEF, 1'b0, 9'd0,   1'b0, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd7,   1'b1, 32'h00AD_00EF};
    vecs[5]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b0, 9'd7,   1'b0, 32'h00AD_00EF};
    vecs[6]  = '{1'b1, 4'hF, 9'd3,   32'h1234_5678, 1'b1, 9'd3,   1'b1, EXP_SAME};
    vecs[7]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd3,   1'b1, 32'h1234_5678};
    vecs[8]  = '{1'b1, 4'h0, 9'd5,   32'hFFFF_FFFF, 1'b1, 9'd5,   1'b1, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd5,   1'b1, 32'h0};
    vecs[10] = '{1'b1, 4'h8, 9'd9,   32'hAABB_CCDD, 1'b1, 9'd7,   1'b1, 32'h00AD_00EF};
    vecs[11] = '{1'b0, 4'h0, 9'd0,   32'h0,         1'b1, 9'd9,   1'b1, 32'hAA00_0000};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low_cnt;
    model_reset();
    #3;
    check("reset_outputs", 64'({a_ready, a_rvalid, a_rdata}), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Initial walk: A ready after edge 512, B after edge 100.
    for (int k = 1; k <= 512; k++) begin
      idle_a();
      check("b_ready_walk", 64'(b_ready), 64'(k >= 100));
    end

    // Instance B: out-of-range write dropped, out-of-range read returns the init value.
    b_we = 1'b1; b_wmask = 4'hF; b_waddr = 7'd99; b_wdata = 32'h1122_3344; b_re = 1'b1; b_raddr = 7'd120;
    idle_a();
    check("b_oor_read", 64'({b_rvalid, b_rdata}), 64'({1'b1, INIT_B}));
    b_waddr = 7'd120; b_wdata = 32'hFFFF_FFFF; b_raddr = 7'd99;
    idle_a();
    check("b_last_entry", 64'({b_rvalid, b_rdata}), 64'({1'b1, 32'h1122_3344}));
    b_we = 1'b0;
    for (int j = 0; j < 3; j++) begin
      b_raddr = (j == 0) ? 7'd20 : (j == 1) ? 7'd56 : 7'd120;
      idle_a();
      check("b_dropped_write", 64'({b_rvalid, b_rdata}), 64'({1'b1, INIT_B}));
    end
    b_re = 1'b0;
    idle_a();
    check("b_idle_hold", 64'({b_ready, b_rvalid, b_rdata}), 64'({2'b10, INIT_B}));

    // Directed vectors on instance A.
    for (int v = 0; v < 12; v++) begin
      cyc_a(vecs[v].we, vecs[v].mask, vecs[v].waddr, vecs[v].wdata, vecs[v].re, vecs[v].raddr, 1'b0);
      check($sformatf("vec%0d", v), 64'({a_ready, a_rvalid, a_rdata}),
            64'({1'b1, vecs[v].exp_rvalid, vecs[v].exp_rdata}));
    end

    // Flush with a concurrent write and read; the read completes, the write is cleared.
    for (int i = 0; i < 10; i++) cyc_a(1'b1, 4'hF, 9'(i), 32'h1000_0000 + i, 1'b0, 9'd0, 1'b0);
    cyc_a(1'b1, 4'hF, 9'd20, 32'hCAFE_F00D, 1'b1, 9'd5, 1'b1);
    check("flush_same_cycle_read", 64'({a_rvalid, a_rdata}), 64'({1'b1, 32'h1000_0005}));
    low_cnt = 0;
    for (int c = 0; c < 600 && !a_ready; c++) begin
      low_cnt++;
      cyc_a(1'b1, 4'hF, 9'(c % 16), 32'h5555_AAAA, 1'($urandom_range(0, 1)), 9'(c % 16), 1'b0);
      if (!a_ready) check("flush_rvalid_low", 64'(a_rvalid), 64'h0);
    end
    check("flush_ready_low_cycles", 64'(low_cnt), 64'd512);
    for (int i = 0; i <= 10; i++) begin
      read_a((i == 10) ? 9'd20 : 9'(i));
      check("flush_cleared", 64'({a_rvalid, a_rdata}), 64'({1'b1, INIT_A}));
    end

    // Randomised traffic against the model, with an occasional flush.
    for (int r = 0; r < 400; r++) begin
      logic [8:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      cyc_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom,
            1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 299) == 0));
    end
    while (m_busy > 0) idle_a();

    // Reset in the middle of an accepted read clears rvalid at once.
    read_a(9'd3);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_read", 64'({a_ready, a_rvalid, a_rdata}), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset at walk cycle 40 restarts the full walk.
    for (int c = 0; c < 40; c++) idle_a();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_walk", 64'({a_ready, a_rvalid}), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 600 && !a_ready; c++) begin
      idle_a();
      if (!a_ready) low_cnt++;
    end
    check("rst_walk_restart_cycles", 64'(low_cnt), 64'd511);
    read_a(9'd0);
    check("rst_walk_read0", 64'({a_rvalid, a_rdata}), 64'({1'b1, INIT_A}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
